// File: rtl/dmem_pkg.sv
// Shared constants and types for the wait-state data memory.
package dmem_pkg;

   // Access size encodings; 2'b11 is treated as a word access.
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Request FSM state encodings.
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Width of the wait-state counter (0..15 extra cycles).
   localparam int WAIT_W = 4;

   // Request fields captured when the FSM accepts a request.
   typedef struct packed {
      logic        rw;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] di;
   } req_t;

endpackage

// File: rtl/byte_lane_align.sv
// Read-side lane steering: picks byte/half/word out of the four bytes that
// start at the access address, applies sign/zero extension and flags
// misalignment. raw_i[0] is the byte at the access address itself.
module byte_lane_align
   import dmem_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b1
)(
   input  logic [3:0][7:0] raw_i,
   input  logic [1:0]      size_i,
   input  logic            sgn_i,
   input  logic [1:0]      addr_lo_i,
   output logic [31:0]     data_o,
   output logic            misalign_o
);

   logic [15:0] half;
   logic [31:0] data;
   logic        mis;

   // Extract, extend and zero the result on a misaligned access.
   always_comb begin
      half = BIG_ENDIAN ? {raw_i[0], raw_i[1]} : {raw_i[1], raw_i[0]};
      mis  = 1'b0;
      data = '0;
      case (size_i)
         SZ_BYTE: data = {{24{sgn_i & raw_i[0][7]}}, raw_i[0]};
         SZ_HALF: begin
            mis  = addr_lo_i[0];
            data = {{16{sgn_i & half[15]}}, half};
         end
         default: begin
            mis  = (addr_lo_i != 2'b00);
            data = BIG_ENDIAN ? {raw_i[0], raw_i[1], raw_i[2], raw_i[3]} : raw_i;
         end
      endcase
      misalign_o = mis;
      data_o     = mis ? 32'h0 : data;
   end

endmodule

// File: rtl/dmem_wait_ctrl.sv
// MEM-stage data memory with programmable wait states. A request is captured
// in IDLE, counted down in BUSY, performed on the BUSY->DONE edge and
// acknowledged by a one-cycle done pulse. stall freezes the front of the
// pipeline until the DONE cycle.
module dmem_wait_ctrl
   import dmem_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int WAIT_STATES = 0,
   parameter bit BIG_ENDIAN  = 1'b1
)(
   input  logic              clk,
   input  logic              R,
   input  logic              E,
   input  logic              RW,
   input  logic [1:0]        Size,
   input  logic              Sgn,
   input  logic [ADDR_W-1:0] Addd,
   input  logic [31:0]       DI,
   output logic [31:0]       DO,
   output logic              stall,
   output logic              done,
   output logic              err
);

   localparam int DEPTH = 2**ADDR_W;

   // Storage is deliberately left out of reset so contents survive R.
   reg [7:0] Mem [0:DEPTH-1];

   logic [1:0]        state_q, state_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q;
   req_t              req_q;
   logic [31:0]       do_q;
   logic              err_q;

   logic              capture, finish, commit, mis;
   logic [31:0]       rd_data;
   logic [3:0][7:0]   raw, wdat;
   logic [3:0]        we;
   logic [ADDR_W-1:0] idx [4];

   // Byte indices wrap naturally at DEPTH through ADDR_W-bit arithmetic.
   for (genvar k = 0; k < 4; k++) begin : g_lane
      assign idx[k] = addr_q + ADDR_W'(k);
      assign raw[k] = Mem[idx[k]];
   end

   byte_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
      .raw_i      (raw),
      .size_i     (req_q.size),
      .sgn_i      (req_q.sgn),
      .addr_lo_i  (addr_q[1:0]),
      .data_o     (rd_data),
      .misalign_o (mis)
   );

   // Next-state logic; E seen in DONE belongs to the finishing request.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      finish  = 1'b0;
      case (state_q)
         S_IDLE: if (E) begin
            capture = 1'b1;
            cnt_d   = WAIT_W'(WAIT_STATES);
            state_d = S_BUSY;
         end
         S_BUSY: begin
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            else begin
               finish  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign commit = finish & req_q.rw & ~mis;

   // Write lane enables and data, placed according to endianness.
   always_comb begin
      we   = '0;
      wdat = '0;
      case (req_q.size)
         SZ_BYTE: begin
            we      = 4'b0001;
            wdat[0] = req_q.di[7:0];
         end
         SZ_HALF: begin
            we      = 4'b0011;
            wdat[0] = BIG_ENDIAN ? req_q.di[15:8] : req_q.di[7:0];
            wdat[1] = BIG_ENDIAN ? req_q.di[7:0]  : req_q.di[15:8];
         end
         default: begin
            we   = 4'b1111;
            wdat = BIG_ENDIAN ? {req_q.di[7:0], req_q.di[15:8], req_q.di[23:16], req_q.di[31:24]}
                              : req_q.di;
         end
      endcase
      if (!commit) we = '0;
   end

   // FSM, counter, request capture and registered results.
   always_ff @(posedge clk or posedge R) begin
      if (R) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         req_q   <= '0;
         do_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (capture) begin
            addr_q   <= Addd;
            req_q.rw <= RW;
            req_q.size <= Size;
            req_q.sgn  <= Sgn;
            req_q.di   <= DI;
         end
         if (finish) begin
            err_q <= mis;
            if (mis)             do_q <= '0;
            else if (!req_q.rw)  do_q <= rd_data;
         end
      end
   end

   // Memory write port; only touched on the completing edge of a legal write.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++)
         if (we[k]) Mem[idx[k]] <= wdat[k];
   end

   assign DO    = do_q;
   assign done  = (state_q == S_DONE);
   assign err   = err_q & done;
   assign stall = E & (state_q != S_DONE);

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Directed bench for dmem_wait_ctrl: three instances (W=0 big-endian,
// W=3 little-endian, W=5 big-endian) sharing the request bus, each with
// its own enable.
module tb_dmem_wait_ctrl;
   import dmem_pkg::*;

   logic        clk = 1'b0;
   logic        R, RW, Sgn;
   logic [1:0]  Size;
   logic [7:0]  Addd;
   logic [31:0] DI;
   logic        e    [3];
   logic [31:0] dout [3];
   logic        stl  [3];
   logic        dn   [3];
   logic        er   [3];

   int checks   = 0;
   int failures = 0;
   int W_OF [3] = '{0, 3, 5};

   always #5 clk = ~clk;

   dmem_wait_ctrl #(.ADDR_W(8), .WAIT_STATES(0), .BIG_ENDIAN(1'b1)) u_w0 (
      .clk(clk), .R(R), .E(e[0]), .RW(RW), .Size(Size), .Sgn(Sgn), .Addd(Addd), .DI(DI),
      .DO(dout[0]), .stall(stl[0]), .done(dn[0]), .err(er[0]));
   dmem_wait_ctrl #(.ADDR_W(8), .WAIT_STATES(3), .BIG_ENDIAN(1'b0)) u_w3 (
      .clk(clk), .R(R), .E(e[1]), .RW(RW), .Size(Size), .Sgn(Sgn), .Addd(Addd), .DI(DI),
      .DO(dout[1]), .stall(stl[1]), .done(dn[1]), .err(er[1]));
   dmem_wait_ctrl #(.ADDR_W(8), .WAIT_STATES(5), .BIG_ENDIAN(1'b1)) u_w5 (
      .clk(clk), .R(R), .E(e[2]), .RW(RW), .Size(Size), .Sgn(Sgn), .Addd(Addd), .DI(DI),
      .DO(dout[2]), .stall(stl[2]), .done(dn[2]), .err(er[2]));

   typedef struct {
      int          u;
      logic        rw;
      logic [1:0]  sz;
      logic        sgn;
      logic [7:0]  a;
      logic [31:0] d;
      logic [31:0] exp_do;
      logic        exp_err;
      string       name;
   } vec_t;

   vec_t tbl [$];

   function automatic void add(input int u, input logic rw, input logic [1:0] sz, input logic sgn,
                               input logic [7:0] a, input logic [31:0] d, input logic [31:0] exp_do,
                               input logic exp_err, input string name);
      vec_t v;
      v.u = u; v.rw = rw; v.sz = sz; v.sgn = sgn; v.a = a; v.d = d;
      v.exp_do = exp_do; v.exp_err = exp_err; v.name = name;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one request on instance u, hold E until the done cycle, report
   // latency, whether stall was high before done and low in done, DO and err.
   task automatic run_req(input int u, input logic rw, input logic [1:0] sz, input logic sgn,
                          input logic [7:0] a, input logic [31:0] d, output int lat,
                          output logic st_ok, output logic [31:0] d_o, output logic e_o);
      RW = rw; Size = sz; Sgn = sgn; Addd = a; DI = d; e[u] = 1'b1;
      lat = -1; st_ok = 1'b1; d_o = '0; e_o = 1'b0;
      for (int c = 0; c < 40 && lat < 0; c++) begin
         @(negedge clk);
         if (dn[u]) begin
            lat = c; st_ok &= ~stl[u]; d_o = dout[u]; e_o = er[u];
         end else st_ok &= stl[u];
         @(posedge clk); #1;
      end
      e[u] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int          lat;
      logic        st_ok, e_o;
      logic [31:0] d_o;
      logic [5:0]  dn_seq, st_seq;
      logic [31:0] do_c2;
      int          done_c, done_cnt;
      logic        st_any;

      // W=0, big-endian
      add(0, 1, SZ_WORD, 0, 8'd52,  32'h12345678, 32'h00000000, 0, "w0_wr_word52");
      add(0, 0, SZ_WORD, 0, 8'd52,  32'h0,        32'h12345678, 0, "w0_rd_word52");
      add(0, 1, SZ_BYTE, 0, 8'd56,  32'h000000F0, 32'h12345678, 0, "w0_wr_byte56");
      add(0, 0, SZ_BYTE, 1, 8'd56,  32'h0,        32'hFFFFFFF0, 0, "w0_rd_sbyte56");
      add(0, 0, SZ_BYTE, 0, 8'd56,  32'h0,        32'h000000F0, 0, "w0_rd_ubyte56");
      add(0, 0, SZ_HALF, 1, 8'd52,  32'h0,        32'h00001234, 0, "w0_rd_shalf52");
      add(0, 0, SZ_HALF, 0, 8'd54,  32'h0,        32'h00005678, 0, "w0_rd_uhalf54");
      add(0, 0, SZ_BYTE, 1, 8'd53,  32'h0,        32'h00000034, 0, "w0_rd_sbyte53");
      add(0, 1, SZ_HALF, 0, 8'd60,  32'h00008001, 32'h00000034, 0, "w0_wr_half60");
      add(0, 0, SZ_HALF, 1, 8'd60,  32'h0,        32'hFFFF8001, 0, "w0_rd_shalf60");
      add(0, 0, SZ_HALF, 0, 8'd60,  32'h0,        32'h00008001, 0, "w0_rd_uhalf60");
      add(0, 0, SZ_WORD, 0, 8'd53,  32'h0,        32'h00000000, 1, "w0_mis_word53");
      add(0, 0, SZ_HALF, 0, 8'd57,  32'h0,        32'h00000000, 1, "w0_mis_half57");
      add(0, 0, 2'b11,   0, 8'd52,  32'h0,        32'h12345678, 0, "w0_rd_sz11_52");
      add(0, 1, SZ_WORD, 0, 8'd54,  32'hFFFFFFFF, 32'h00000000, 1, "w0_mis_wr54");
      add(0, 0, SZ_WORD, 0, 8'd52,  32'h0,        32'h12345678, 0, "w0_rd_after_mis");
      add(0, 0, SZ_BYTE, 0, 8'd56,  32'h0,        32'h000000F0, 0, "w0_rd_b56_after_mis");
      add(0, 1, SZ_WORD, 0, 8'd252, 32'hCAFEBABE, 32'h000000F0, 0, "w0_wr_word252");
      add(0, 0, SZ_WORD, 0, 8'd252, 32'h0,        32'hCAFEBABE, 0, "w0_rd_word252");
      add(0, 0, SZ_WORD, 0, 8'd254, 32'h0,        32'h00000000, 1, "w0_mis_word254");
      add(0, 0, SZ_BYTE, 1, 8'd255, 32'h0,        32'hFFFFFFBE, 0, "w0_rd_sbyte255");
      add(0, 1, SZ_HALF, 0, 8'd255, 32'h00001111, 32'h00000000, 1, "w0_mis_wr_half255");
      // W=3, little-endian
      add(1, 1, SZ_BYTE, 0, 8'd59,  32'h0000003C, 32'h00000000, 0, "w3_wr_byte59");
      add(1, 1, SZ_BYTE, 0, 8'd58,  32'h123456A5, 32'h00000000, 0, "w3_wr_byte58");
      add(1, 0, SZ_BYTE, 0, 8'd58,  32'h0,        32'h000000A5, 0, "w3_rd_ubyte58");
      add(1, 0, SZ_BYTE, 1, 8'd59,  32'h0,        32'h0000003C, 0, "w3_rd_sbyte59");
      add(1, 1, SZ_WORD, 0, 8'd64,  32'h11223344, 32'h0000003C, 0, "w3_wr_word64");
      add(1, 0, SZ_WORD, 0, 8'd64,  32'h0,        32'h11223344, 0, "w3_rd_word64");
      add(1, 0, SZ_HALF, 0, 8'd66,  32'h0,        32'h00001122, 0, "w3_rd_uhalf66");
      add(1, 0, SZ_HALF, 1, 8'd64,  32'h0,        32'h00003344, 0, "w3_rd_shalf64");
      add(1, 0, SZ_BYTE, 1, 8'd67,  32'h0,        32'h00000011, 0, "w3_rd_sbyte67");
      add(1, 1, SZ_HALF, 0, 8'd68,  32'h0000BEEF, 32'h00000011, 0, "w3_wr_half68");
      add(1, 0, SZ_HALF, 1, 8'd68,  32'h0,        32'hFFFFBEEF, 0, "w3_rd_shalf68");
      add(1, 0, SZ_WORD, 0, 8'd66,  32'h0,        32'h00000000, 1, "w3_mis_word66");
      // W=5, big-endian
      add(2, 1, SZ_WORD, 0, 8'd80,  32'hAABBCCDD, 32'h00000000, 0, "w5_wr_word80");
      add(2, 0, SZ_WORD, 0, 8'd80,  32'h0,        32'hAABBCCDD, 0, "w5_rd_word80");

      // Reset state
      R = 1'b1; RW = 1'b0; Size = 2'b00; Sgn = 1'b0; Addd = '0; DI = '0;
      for (int u = 0; u < 3; u++) e[u] = 1'b0;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      for (int u = 0; u < 3; u++) begin
         chk($sformatf("rst_do%0d", u),    dout[u], 32'h0);
         chk($sformatf("rst_done%0d", u),  dn[u],   1'b0);
         chk($sformatf("rst_err%0d", u),   er[u],   1'b0);
         chk($sformatf("rst_stall%0d", u), stl[u],  1'b0);
      end
      @(posedge clk); #1;
      R = 1'b0;

      // Table-driven requests
      foreach (tbl[i]) begin
         run_req(tbl[i].u, tbl[i].rw, tbl[i].sz, tbl[i].sgn, tbl[i].a, tbl[i].d, lat, st_ok, d_o, e_o);
         chk({tbl[i].name, "/lat"},   lat,   W_OF[tbl[i].u] + 2);
         chk({tbl[i].name, "/stall"}, st_ok, 1'b1);
         chk({tbl[i].name, "/do"},    d_o,   tbl[i].exp_do);
         chk({tbl[i].name, "/err"},   e_o,   tbl[i].exp_err);
      end

      // Memory side effects: byte write touches one lane, misaligned writes none
      chk("w3_mem58", u_w3.Mem[58], 32'hA5);
      chk("w3_mem59", u_w3.Mem[59], 32'h3C);
      chk("w0_mem53", u_w0.Mem[53], 32'h34);
      chk("w0_mem54", u_w0.Mem[54], 32'h56);
      chk("w0_mem55", u_w0.Mem[55], 32'h78);
      chk("w0_mem56", u_w0.Mem[56], 32'hF0);
      chk("w0_mem255", u_w0.Mem[255], 32'hBE);

      // Back-to-back reads with E held, W=0
      RW = 1'b0; Size = SZ_WORD; Sgn = 1'b0; Addd = 8'd52; e[0] = 1'b1;
      dn_seq = '0; st_seq = '0; do_c2 = '0;
      for (int c = 0; c < 6; c++) begin
         if (c == 3) begin Size = SZ_BYTE; Sgn = 1'b1; Addd = 8'd56; end
         @(negedge clk);
         dn_seq[c] = dn[0];
         st_seq[c] = stl[0];
         if (c == 2) do_c2 = dout[0];
         if (c == 5) d_o = dout[0];
         @(posedge clk); #1;
      end
      e[0] = 1'b0;
      chk("b2b_done_seq",  dn_seq, 6'b100100);
      chk("b2b_stall_seq", st_seq, 6'b011011);
      chk("b2b_do1", do_c2, 32'h12345678);
      chk("b2b_do2", d_o,   32'hFFFFFFF0);

      // Flush: E drops after acceptance, access still completes, W=3
      RW = 1'b0; Size = SZ_WORD; Sgn = 1'b0; Addd = 8'd64; e[1] = 1'b1;
      @(negedge clk); @(posedge clk); #1;
      e[1] = 1'b0;
      done_c = -1; st_any = 1'b0;
      for (int c = 1; c < 12; c++) begin
         @(negedge clk);
         if (dn[1] && done_c < 0) begin done_c = c; d_o = dout[1]; end
         st_any |= stl[1];
         @(posedge clk); #1;
      end
      chk("flush_done_cycle", done_c, 5);
      chk("flush_stall_low",  st_any, 1'b0);
      chk("flush_do",         d_o,    32'h11223344);

      // Reset in cycle 3 of a W=5 write
      RW = 1'b1; Size = SZ_WORD; Sgn = 1'b0; Addd = 8'd80; DI = 32'h01020304; e[2] = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); @(posedge clk); #1;
      end
      R = 1'b1; e[2] = 1'b0;
      @(negedge clk);
      chk("rmid_done",  dn[2],   1'b0);
      chk("rmid_do",    dout[2], 32'h0);
      chk("rmid_stall", stl[2],  1'b0);
      chk("rmid_state", u_w5.state_q, S_IDLE);
      @(posedge clk); #1;
      R = 1'b0;
      done_cnt = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (dn[2]) done_cnt++;
         @(posedge clk); #1;
      end
      chk("rmid_no_done", done_cnt, 0);
      chk("rmid_mem80", u_w5.Mem[80], 32'hAA);
      chk("rmid_mem81", u_w5.Mem[81], 32'hBB);
      chk("rmid_mem82", u_w5.Mem[82], 32'hCC);
      chk("rmid_mem83", u_w5.Mem[83], 32'hDD);
      run_req(2, 1'b0, SZ_WORD, 1'b0, 8'd80, 32'h0, lat, st_ok, d_o, e_o);
      chk("rmid_next/lat",   lat,   7);
      chk("rmid_next/stall", st_ok, 1'b1);
      chk("rmid_next/do",    d_o,   32'hAABBCCDD);
      chk("rmid_next/err",   e_o,   1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
